// File: rtl/id_operand_stage.sv
// Decode/operand-fetch stage feeding the ALU: splits the instruction word, reads
// RS/RT from a 32x32 register file with writeback bypass, and holds one output beat.
module id_operand_stage #(
   parameter int         DATA_W   = 32,
   parameter int         NREGS    = 32,
   parameter logic [5:0] RTYPE_OP = 6'b000000
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [31:0]       IN_INSTR,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic              WB_EN,
   input  logic [4:0]        WB_ADDR,
   input  logic [DATA_W-1:0] WB_DATA,
   input  logic              FLUSH,
   input  logic              OUT_READY,
   output logic              OUT_VALID,
   output logic [5:0]        OPCODE,
   output logic [DATA_W-1:0] RS_VAL,
   output logic [DATA_W-1:0] RT_VAL,
   output logic [4:0]        SHAMT,
   output logic [5:0]        FUNC,
   output logic [15:0]       RAW_VAL,
   output logic [4:0]        DST_ADDR
);

   logic [DATA_W-1:0] r_regs [NREGS];
   logic              r_outValid;
   logic [5:0]        r_opcode;
   logic [DATA_W-1:0] r_rsVal;
   logic [DATA_W-1:0] r_rtVal;
   logic [4:0]        r_shamt;
   logic [5:0]        r_func;
   logic [15:0]       r_rawVal;
   logic [4:0]        r_dstAddr;
   logic [4:0]        r_rsAddr;
   logic [4:0]        r_rtAddr;

   logic [4:0]        w_rsAddr;
   logic [4:0]        w_rtAddr;
   logic [5:0]        w_opcode;
   logic [DATA_W-1:0] w_rsVal;
   logic [DATA_W-1:0] w_rtVal;
   logic              w_inReady;
   logic              w_accept;
   logic              w_wbLive;

   assign w_opcode  = IN_INSTR[31:26];
   assign w_rsAddr  = IN_INSTR[25:21];
   assign w_rtAddr  = IN_INSTR[20:16];
   assign w_inReady = !r_outValid || OUT_READY;
   assign w_accept  = IN_VALID && w_inReady && !FLUSH;
   assign w_wbLive  = WB_EN && (WB_ADDR != 5'd0);

   // Operand read: r0 is hardwired to zero, and a same-cycle write is forwarded.
   always_comb begin
      w_rsVal = '0;
      w_rtVal = '0;
      if (w_rsAddr != 5'd0) begin
         w_rsVal = (w_wbLive && WB_ADDR == w_rsAddr) ? WB_DATA : r_regs[w_rsAddr];
      end
      if (w_rtAddr != 5'd0) begin
         w_rtVal = (w_wbLive && WB_ADDR == w_rtAddr) ? WB_DATA : r_regs[w_rtAddr];
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wbLive) begin
         r_regs[WB_ADDR] <= WB_DATA;
      end
   end

   // Output beat register; held operands track writebacks so a stalled beat never goes stale.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_outValid <= 1'b0;
         r_opcode   <= '0;
         r_rsVal    <= '0;
         r_rtVal    <= '0;
         r_shamt    <= '0;
         r_func     <= '0;
         r_rawVal   <= '0;
         r_dstAddr  <= '0;
         r_rsAddr   <= '0;
         r_rtAddr   <= '0;
      end else if (w_accept) begin
         r_outValid <= 1'b1;
         r_opcode   <= w_opcode;
         r_rsVal    <= w_rsVal;
         r_rtVal    <= w_rtVal;
         r_shamt    <= IN_INSTR[10:6];
         r_func     <= IN_INSTR[5:0];
         r_rawVal   <= IN_INSTR[15:0];
         r_dstAddr  <= (w_opcode == RTYPE_OP) ? IN_INSTR[15:11] : w_rtAddr;
         r_rsAddr   <= w_rsAddr;
         r_rtAddr   <= w_rtAddr;
      end else begin
         if (FLUSH || OUT_READY) begin
            r_outValid <= 1'b0;
         end
         if (w_wbLive && WB_ADDR == r_rsAddr) begin
            r_rsVal <= WB_DATA;
         end
         if (w_wbLive && WB_ADDR == r_rtAddr) begin
            r_rtVal <= WB_DATA;
         end
      end
   end

   assign IN_READY  = w_inReady;
   assign OUT_VALID = r_outValid;
   assign OPCODE    = r_opcode;
   assign RS_VAL    = r_rsVal;
   assign RT_VAL    = r_rtVal;
   assign SHAMT     = r_shamt;
   assign FUNC      = r_func;
   assign RAW_VAL   = r_rawVal;
   assign DST_ADDR  = r_dstAddr;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed testbench for id_operand_stage with hand-computed expected values.
module tb_id_operand_stage;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [31:0] IN_INSTR;
   logic        IN_VALID;
   logic        IN_READY;
   logic        WB_EN;
   logic [4:0]  WB_ADDR;
   logic [31:0] WB_DATA;
   logic        FLUSH;
   logic        OUT_READY;
   logic        OUT_VALID;
   logic [5:0]  OPCODE;
   logic [31:0] RS_VAL;
   logic [31:0] RT_VAL;
   logic [4:0]  SHAMT;
   logic [5:0]  FUNC;
   logic [15:0] RAW_VAL;
   logic [4:0]  DST_ADDR;

   int checks = 0;
   int errors = 0;

   id_operand_stage dut (
      .CLK(CLK), .RST_N(RST_N),
      .IN_INSTR(IN_INSTR), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .WB_EN(WB_EN), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
      .FLUSH(FLUSH), .OUT_READY(OUT_READY), .OUT_VALID(OUT_VALID),
      .OPCODE(OPCODE), .RS_VAL(RS_VAL), .RT_VAL(RT_VAL), .SHAMT(SHAMT),
      .FUNC(FUNC), .RAW_VAL(RAW_VAL), .DST_ADDR(DST_ADDR)
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, then return just after the rising edge.
   task automatic applyStimulus(input logic [31:0] instr, input logic valid, input logic outReady,
                                input logic wbEn, input logic [4:0] wbAddr, input logic [31:0] wbData,
                                input logic flush);
      @(negedge CLK);
      IN_INSTR  = instr;
      IN_VALID  = valid;
      OUT_READY = outReady;
      WB_EN     = wbEn;
      WB_ADDR   = wbAddr;
      WB_DATA   = wbData;
      FLUSH     = flush;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      logic [31:0] instr;
      RST_N = 1'b0; IN_INSTR = '0; IN_VALID = 0; OUT_READY = 0;
      WB_EN = 0; WB_ADDR = '0; WB_DATA = '0; FLUSH = 0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;

      // Non-R-type decode, destination from rt, operand from an earlier write
      applyStimulus(32'h0, 0, 1, 1, 5'd3, 32'h0000_00AA, 0);
      applyStimulus(32'h5403_0007, 1, 1, 0, 5'd0, 32'h0, 0);
      checkOutput("lui_valid",  OUT_VALID, 1);
      checkOutput("lui_opcode", OPCODE, 6'b010101);
      checkOutput("lui_rs",     RS_VAL, 0);
      checkOutput("lui_rt",     RT_VAL, 32'hAA);
      checkOutput("lui_raw",    RAW_VAL, 16'h0007);
      checkOutput("lui_func",   FUNC, 6'h07);
      checkOutput("lui_dst",    DST_ADDR, 3);

      // Asynchronous reset between clock edges clears outputs immediately
      #2;
      RST_N = 1'b0;
      IN_VALID = 0;
      WB_EN = 0;
      #1;
      checkOutput("rst_valid",  OUT_VALID, 0);
      checkOutput("rst_opcode", OPCODE, 0);
      checkOutput("rst_rt",     RT_VAL, 0);
      checkOutput("rst_raw",    RAW_VAL, 0);
      checkOutput("rst_dst",    DST_ADDR, 0);
      @(negedge CLK);
      RST_N = 1'b1;

      for (int i = 1; i < 32; i++) begin
         instr = {6'd1, i[4:0], i[4:0], 16'h0};
         applyStimulus(instr, 1, 1, 0, 5'd0, 32'h0, 0);
         checkOutput($sformatf("rst_reg_rs%0d", i), RS_VAL, 0);
         checkOutput($sformatf("rst_reg_rt%0d", i), RT_VAL, 0);
      end
      applyStimulus(32'h0, 0, 1, 0, 5'd0, 32'h0, 0);
      checkOutput("drain_valid", OUT_VALID, 0);

      // R-type with same-cycle writeback bypass on rs
      applyStimulus(32'h0, 0, 1, 1, 5'd2, 32'h0000_0055, 0);
      applyStimulus(32'h0022_1820, 1, 1, 1, 5'd1, 32'h0000_1234, 0);
      checkOutput("rt_valid",  OUT_VALID, 1);
      checkOutput("rt_opcode", OPCODE, 0);
      checkOutput("rt_rs_byp", RS_VAL, 32'h1234);
      checkOutput("rt_rt",     RT_VAL, 32'h55);
      checkOutput("rt_func",   FUNC, 6'b100000);
      checkOutput("rt_shamt",  SHAMT, 0);
      checkOutput("rt_dst",    DST_ADDR, 3);

      // Stall with operand refresh of the held rt register
      applyStimulus(32'h0022_1820, 1, 0, 0, 5'd0, 32'h0, 0);
      checkOutput("st_valid",    OUT_VALID, 1);
      checkOutput("st_inready",  IN_READY, 0);
      applyStimulus(32'h5403_0007, 1, 0, 0, 5'd0, 32'h0, 0);
      checkOutput("st1_opcode",  OPCODE, 0);
      checkOutput("st1_dst",     DST_ADDR, 3);
      checkOutput("st1_rt",      RT_VAL, 32'h55);
      checkOutput("st1_inready", IN_READY, 0);
      applyStimulus(32'h5403_0007, 1, 0, 1, 5'd2, 32'hFFFF_0000, 0);
      checkOutput("st2_rt",      RT_VAL, 32'hFFFF_0000);
      checkOutput("st2_rs",      RS_VAL, 32'h1234);
      checkOutput("st2_func",    FUNC, 6'b100000);
      applyStimulus(32'h0, 0, 0, 0, 5'd0, 32'h0, 0);
      checkOutput("st3_valid",   OUT_VALID, 1);
      checkOutput("st3_rt",      RT_VAL, 32'hFFFF_0000);
      applyStimulus(32'h0, 0, 1, 0, 5'd0, 32'h0, 0);
      checkOutput("st_release",  OUT_VALID, 0);

      // Back-to-back full throughput; writes to r0 must be ignored and not bypassed
      for (int i = 0; i < 4; i++) begin
         instr = {6'd0, 5'd0, 5'd0, 5'd4, 5'd0, 6'(i + 1)};
         applyStimulus(instr, 1, 1, 1, 5'd0, 32'h0000_DEAD, 0);
         checkOutput($sformatf("b2b_valid%0d", i), OUT_VALID, 1);
         checkOutput($sformatf("b2b_func%0d", i), FUNC, 6'(i + 1));
         checkOutput($sformatf("b2b_r0_%0d", i), RS_VAL, 0);
      end
      applyStimulus(32'h0, 0, 1, 0, 5'd0, 32'h0, 0);
      checkOutput("b2b_drain", OUT_VALID, 0);

      // Flush kills the held beat and suppresses the same-cycle accept
      applyStimulus(32'h0022_1820, 1, 0, 0, 5'd0, 32'h0, 0);
      checkOutput("fl_pre_valid", OUT_VALID, 1);
      applyStimulus(32'h5403_0007, 1, 1, 0, 5'd0, 32'h0, 1);
      checkOutput("fl_valid", OUT_VALID, 0);
      applyStimulus(32'h0, 0, 1, 0, 5'd0, 32'h0, 0);
      checkOutput("fl_after", OUT_VALID, 0);
      checkOutput("fl_opcode_not_x", {31'd0, ^{OPCODE, RS_VAL, RT_VAL, RAW_VAL} === 1'bx}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
